// File: rtl/bshift_pkg.sv
// rtl/bshift_pkg.sv - shared mode encodings for the pipelined barrel shifter
package bshift_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bshifter_pipe_if.sv
// rtl/bshifter_pipe_if.sv - input/output stream handshake bundle of the shifter pipeline
interface bshifter_pipe_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mode;

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/bshift_stage.sv
// rtl/bshift_stage.sv - one barrel-shifter stage: conditional shift by DIST, then register
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic [1:0]       out_mode
);
  localparam int BIT = $clog2(DIST);

  logic [WIDTH-1:0] shifted;

  // ASR stays correct across stages because every earlier ASR step kept the original MSB on top
  always_comb begin
    shifted = in_data;
    if (in_amt[BIT]) begin
      case (shift_mode_e'(in_mode))
        MODE_LSL: shifted = in_data << DIST;
        MODE_LSR: shifted = in_data >> DIST;
        MODE_ASR: shifted = {{DIST{in_data[WIDTH-1]}}, in_data[WIDTH-1:DIST]};
        MODE_ROR: shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
        default:  shifted = in_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= 2'b00;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_amt   <= in_amt;
      out_mode  <= in_mode;
    end
  end

endmodule

// File: rtl/bshifter_pipe.sv
// rtl/bshifter_pipe.sv - SHW-stage pipelined barrel shifter with a global stall
module bshifter_pipe
  import bshift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst,
  bshifter_pipe_if.slave bus
);
  logic             stall;
  logic             vld  [SHW+1];
  logic [WIDTH-1:0] dat  [SHW+1];
  logic [SHW-1:0]   amt  [SHW+1];
  logic [1:0]       mode [SHW+1];
  logic [SHW-1:0]   unused_amt;

  assign vld[0]  = bus.in_valid;
  assign dat[0]  = bus.in_data;
  assign amt[0]  = bus.in_amt;
  assign mode[0] = bus.in_mode;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    bshift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .SHW   (SHW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .in_valid  (vld[k]),
      .in_data   (dat[k]),
      .in_amt    (amt[k]),
      .in_mode   (mode[k]),
      .out_valid (vld[k+1]),
      .out_data  (dat[k+1]),
      .out_amt   (amt[k+1]),
      .out_mode  (mode[k+1])
    );
  end

  // Whole pipe freezes together, so a bubble is never squeezed out under backpressure
  assign stall         = vld[SHW] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld[SHW];
  assign bus.out_data  = dat[SHW];
  assign bus.out_mode  = mode[SHW];
  assign unused_amt    = amt[SHW];

endmodule

// File: doc/bshifter_pipe.md
BSHIFTER_PIPE -- requirements
Module: bshifter_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL be a power of two and at least 4.
REQ-002 Parameter SHW, default $clog2(WIDTH), width of the shift amount; SHALL NOT be overridden independently of WIDTH.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the input beat is valid.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 in_mode  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 out_valid  output  1  the result beat is valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_mode  output  2  mode of the result beat, passed through unchanged.

Function
REQ-014 The block SHALL be a pipeline of SHW stages; stage k (k=0 first) SHALL shift by 2^k when amount bit k is 1 and pass the data unchanged otherwise, then register the result.
REQ-015 Amount and mode SHALL be registered alongside the data in every stage.
REQ-016 LSL and LSR SHALL zero-fill, ASR SHALL fill with bit WIDTH-1 of the original operand, and ROR SHALL wrap the low bits into the high end.
REQ-017 Latency SHALL be exactly SHW cycles from an accepted beat (in_valid and in_ready high at the edge) to out_valid, when no stall occurs.
REQ-018 Stall: stall = out_valid and not out_ready; in_ready SHALL equal not stall, combinationally.
REQ-019 While stall is high, every stage register, including its valid bit, SHALL hold.
REQ-020 When stall is low, each stage SHALL load its predecessor's data and valid; stage 0 SHALL load in_valid.
REQ-021 Throughput SHALL be one beat per cycle while out_ready is held high; no bubbles SHALL be inserted.
REQ-022 out_data and out_mode SHALL be stable from the cycle out_valid rises until the beat is accepted.
REQ-023 An amount of 0 SHALL return in_data unchanged in every mode.
REQ-024 A beat presented while in_ready is low SHALL NOT be captured.

Reset
REQ-025 Asserting rst SHALL immediately clear all stage valid bits, so that out_valid is 0 and in_ready is 1.
REQ-026 Asserting rst SHALL immediately clear all stage data, amount and mode registers, so that out_data is 0 and out_mode is 00.
REQ-027 Beats in flight when rst asserts mid-operation SHALL be discarded, not completed.
REQ-028 The first beat SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-029 The mode encodings (LSL, LSR, ASR, ROR) SHALL be defined as named constants in a shared package, bshift_pkg.
REQ-030 One stage SHALL be a sub-module, bshift_stage, parameterised by WIDTH and the stage's shift distance, containing the combinational shift network and the stage register.
REQ-031 The top level SHALL instantiate SHW bshift_stage instances and SHALL contain only the stall logic.

Verification (WIDTH=8, latency 3)
REQ-032 Scenario 1: in_data=8'hD3, in_amt=3, out_ready=1, each mode in consecutive cycles -> results 8'h98, 8'h1A, 8'hFA, 8'h7A on four consecutive cycles, starting 3 cycles after the first beat.
REQ-033 Scenario 2: in_data=8'hB5, in_amt=0, all four modes -> out_data=8'hB5 in every case.
REQ-034 Scenario 3: ASR of 8'h80 by 7 -> 8'hFF; LSR of 8'h80 by 7 -> 8'h01; ROR of 8'h01 by 7 -> 8'h02.
REQ-035 Scenario 4: stream 5 beats with out_ready=0 from cycle 4 for 3 cycles -> in_ready=0 during the stall, no beat lost or duplicated, results in order.
REQ-036 Scenario 5: assert rst with 3 beats in flight -> out_valid=0 and out_data=0 immediately; no stale beat appears after release.
REQ-037 Scenario 6: random stimulus of 1000 beats with random out_ready, checked against a reference model -> zero mismatches and in-order delivery.
